pipeline_stage_chain: RTL
=========================

Name: pipeline_stage_chain

Overview:
- Parametrised replacement for the hand-wired IFID/IDEX/EXM/MWB register set and its scattered enable/flush glue.
- Holds a DEPTH-stage chain of WIDTH-bit payload registers, each with a valid bit.
- Resolves per-stage stall requests, load-use bubble insertion and per-stage flush in one place.
- Counts retired entries. The datapath drives payload in at stage 0 and taps every stage's payload and valid.

Parameters:
DEPTH, 4, number of pipeline stages (2..8)
WIDTH, 32, payload bits per stage
BUBBLE_STAGE, 1, stage that receives a bubble on bubble_req (1..DEPTH-1)
CNT_W, 32, width of retire_count

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active high
in_valid  in  1  new entry offered to stage 0
in_data  in  WIDTH  payload for stage 0
in_ready  out  1  stage 0 captures in_data this edge
stage_stall  in  DEPTH  bit i: stage i cannot advance (e.g. memory wait)
bubble_req  in  1  load-use hazard: hold stages below BUBBLE_STAGE, inject bubble
flush  in  DEPTH  bit i: kill stage i contents at this edge
stage_valid  out  DEPTH  valid bit per stage
stage_data  out  DEPTH*WIDTH  payload per stage, stage i at [i*WIDTH +: WIDTH]
out_valid  out  1  stage_valid[DEPTH-1]
retire  out  1  last stage valid and advancing this cycle
retire_count  out  CNT_W  number of retired entries, saturating
occupancy  out  $clog2(DEPTH+1)  popcount of stage_valid, combinational

Behaviour:
- Reset (RST=1 at edge): all stage_valid=0, all stage_data=0, retire_count=0, halted=0.
- Outputs during reset: in_ready=0, retire=0.
- hold(i) = OR of stage_stall[j] for j>=i, OR (bubble_req AND i<BUBBLE_STAGE). All combinational.

Per stage i, at each edge, highest priority first:
1. RST: clear the stage.
2. flush[i]: valid=0, data=0. Flush overrides hold.
3. hold(i): keep contents.
4. i==BUBBLE_STAGE and bubble_req: valid=0, data=0.
5. i>0 and hold(i-1): valid=0, data=0. The upstream stage is frozen, so a bubble enters.
6. Otherwise load from stage i-1. Stage 0 loads in_valid/in_data; when in_valid=0 it loads valid=0, data=0.

Handshake and retire:
- in_ready = !hold(0) && !RST (&& !halted when the optional feature is compiled in).
- A transfer occurs when in_valid && in_ready.
- retire = stage_valid[DEPTH-1] && !stage_stall[DEPTH-1] && !flush[DEPTH-1].
- retire_count increments by 1 per retire and saturates at 2^CNT_W-1 (no wrap).

Latency and occupancy:
- An entry accepted at edge k appears on out_valid after edge k+DEPTH-1 when no holds occur.
- Each hold cycle adds one cycle of latency.
- A data word is never duplicated or dropped except by flush.
- occupancy is the popcount of stage_valid, range 0..DEPTH.

Simultaneous events:
- stall[j] with flush[j]: stage j is cleared; stages <j still hold.
- bubble_req with stall[j], j>=BUBBLE_STAGE: the stall dominates and stage BUBBLE_STAGE holds (no bubble).
- Flush of a stage that is also the source of an advance: downstream receives the pre-flush contents only if not itself flushed. Flush is applied to the destination register, not the source.

Optional Feature:
Macro: PIPE_HALT_EN

With PIPE_HALT_EN defined:
- Extra ports: halt_in (in, 1) and halted (out, 1).
- A halt sideband bit travels with each entry, captured with in_data.
- When an entry carrying halt=1 retires, halted is set at that edge and stays set until RST.
- While halted: in_ready=0, stage 0 loads bubbles, and all other stages continue to drain normally.

Without PIPE_HALT_EN: no halt ports, no halted state.

Test Plan:
- Streaming: RST, then in_valid=1 with data 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, no holds. Required: 0x11 out_valid 3 cycles after acceptance, one retire per cycle, retire_count=5, occupancy peaks at 4.
- Memory stall: stage_stall[2]=1 for 3 cycles with stages 0..2 full. Required: stages 0..2 hold, in_ready=0, stage 3 receives a bubble each cycle, no entries lost, retire_count matches accepted count after drain.
- Load-use bubble: bubble_req=1 for 1 cycle with stage 0 = 0xA0, stage 1 = 0xB0. Required: stage 0 keeps 0xA0, stage 1 valid=0 data=0, stage 2 = 0xB0, in_ready=0 that cycle.
- Branch flush: flush=4'b0011 while stage_stall[1]=1. Required: stages 0,1 cleared (flush beats stall), stage 2 gets a bubble, stage 3 advances and retires normally.
- Saturation and reset: CNT_W=4, retire 17 entries. Required: retire_count stops at 15. Asserting RST mid-stream clears valids, data and count at the next edge.
- PIPE_HALT_EN: entry 0x77 with halt_in=1 followed by 0x88. Required: halted rises the edge 0x77 retires, 0x88 (already in flight) still retires, in_ready=0 thereafter until RST.

Source files
------------

// File: rtl/pipeline_stage_chain.sv
// DEPTH-stage valid/payload chain with central stall, bubble and flush resolution; entry latency DEPTH-1 edges plus one per hold cycle.
// Backpressure: any downstream stall freezes every upstream stage and drops in_ready; PIPE_HALT_EN adds a halt sideband that stops intake.
module pipeline_stage_chain #(
  parameter int DEPTH        = 4,
  parameter int WIDTH        = 32,
  parameter int BUBBLE_STAGE = 1,
  parameter int CNT_W        = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           stage_stall,
  input  logic                       bubble_req,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic                       out_valid,
  output logic                       retire,
  output logic [CNT_W-1:0]           retire_count,
`ifdef PIPE_HALT_EN
  input  logic                       halt_in,
  output logic                       halted,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             intake_open;

`ifdef PIPE_HALT_EN
  logic [DEPTH-1:0] halt_q;
  logic [DEPTH-1:0] src_halt;
  logic             halted_q;
  assign intake_open = !halted_q;
  assign halted      = halted_q;
`else
  assign intake_open = 1'b1;
`endif

  // A stall anywhere downstream freezes this stage; bubble_req freezes stages above the bubble slot.
  always_comb begin
    hold = '0;
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold[i] = (|(stage_stall >> i)) || (bubble_req && (i < BUBBLE_STAGE));
    end
    for (int i = 1; i < DEPTH; i++) begin
      kill[i] = hold[i-1] || (bubble_req && (i == BUBBLE_STAGE));
    end
  end

  always_comb begin
    src_valid   = '0;
    src_valid[0] = in_valid && intake_open;
    src_data[0] = src_valid[0] ? in_data : '0;
`ifdef PIPE_HALT_EN
    src_halt    = '0;
    src_halt[0] = src_valid[0] && halt_in;
`endif
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
`ifdef PIPE_HALT_EN
      src_halt[i]  = halt_q[i-1];
`endif
    end
  end

  // Flush acts on the destination register, so it beats hold and never affects what moves downstream.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (RST || flush[i] || (!hold[i] && kill[i])) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
`ifdef PIPE_HALT_EN
        halt_q[i]  <= 1'b0;
`endif
      end else if (!hold[i]) begin
        valid_q[i] <= src_valid[i];
        data_q[i]  <= src_data[i];
`ifdef PIPE_HALT_EN
        halt_q[i]  <= src_halt[i];
`endif
      end
    end
  end

  assign retire = valid_q[DEPTH-1] && !stage_stall[DEPTH-1] && !flush[DEPTH-1] && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      retire_count <= '0;
    end else if (retire && (retire_count != {CNT_W{1'b1}})) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

`ifdef PIPE_HALT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      halted_q <= 1'b0;
    end else if (retire && halt_q[DEPTH-1]) begin
      halted_q <= 1'b1;
    end
  end
`endif

  assign in_ready    = !hold[0] && !RST && intake_open;
  assign stage_valid = valid_q;
  assign out_valid   = valid_q[DEPTH-1];

  always_comb begin
    stage_data = '0;
    occupancy  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_data[i*WIDTH +: WIDTH] = data_q[i];
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

endmodule
